// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and access-check helpers for the load/store unit
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} lsu_state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
      return st ? f3[2] : f3 == 3'b111;
   endfunction
   // funct3[1:0] is the access size for both signed and unsigned loads
   function automatic logic addr_misaligned(input logic [1:0] sz, input logic [2:0] a);
      return sz == 2'd1 ? a[0] : sz == 2'd2 ? |a[1:0] : sz == 2'd3 ? |a : 1'b0;
   endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte-lane extraction/extension for loads and lane merge for read-modify-write stores
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [63:0] store_data,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] load_val,
   output logic [63:0] wdata
);
   logic [5:0]  sh;
   logic [63:0] lane;
   logic [63:0] size_mask;
   always_comb begin
      sh = {offset, 3'b000};
      lane = rdata >> sh;
      size_mask = funct3[1:0] == 2'd0 ? 64'h0000_0000_0000_00FF :
                  funct3[1:0] == 2'd1 ? 64'h0000_0000_0000_FFFF :
                  funct3[1:0] == 2'd2 ? 64'h0000_0000_FFFF_FFFF : '1;
      load_val = funct3 == F3_D  ? lane :
                 funct3 == F3_B  ? {{56{lane[7]}}, lane[7:0]} :
                 funct3 == F3_H  ? {{48{lane[15]}}, lane[15:0]} :
                 funct3 == F3_W  ? {{32{lane[31]}}, lane[31:0]} :
                 funct3 == F3_BU ? {56'd0, lane[7:0]} :
                 funct3 == F3_HU ? {48'd0, lane[15:0]} :
                 funct3 == F3_WU ? {32'd0, lane[31:0]} : lane;
      wdata = (rdata & ~(size_mask << sh)) | ((store_data & size_mask) << sh);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV64I load/store sequencer on a doubleword memory with RMW for narrow stores
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [63:0] load_data,
   output logic        misaligned,
   output logic        illegal,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_wr,
   input  logic [63:0] mem_rdata
);
   lsu_state_t  state;
   logic        st_q;
   logic [2:0]  f3_q;
   logic [2:0]  off_q;
   logic [2:0]  cnt;
   logic [63:0] sd_q;
   logic [63:0] rdata_q;
   logic        mis_q;
   logic        ill_q;
   logic        err_ill;
   logic        err_mis;
   logic [63:0] lane_load;
   logic [63:0] lane_wdata;
   assign err_ill = f3_illegal(is_store, funct3);
   assign err_mis = addr_misaligned(funct3[1:0], addr[2:0]);
   assign busy = state != IDLE;
   lsu_lane u_lane (
      .rdata(rdata_q),
      .store_data(sd_q),
      .offset(off_q),
      .funct3(f3_q),
      .load_val(lane_load),
      .wdata(lane_wdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done <= 1'b0;
         load_data <= '0;
         misaligned <= 1'b0;
         illegal <= 1'b0;
         mem_wr <= 1'b0;
         mem_wdata <= '0;
         mem_addr <= '0;
         st_q <= 1'b0;
         f3_q <= '0;
         off_q <= '0;
         sd_q <= '0;
         rdata_q <= '0;
         cnt <= '0;
         mis_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         done <= 1'b0;
         misaligned <= 1'b0;
         illegal <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            IDLE: if (start) begin
               st_q <= is_store;
               f3_q <= funct3;
               off_q <= addr[2:0];
               sd_q <= store_data;
               ill_q <= err_ill;
               mis_q <= !err_ill && err_mis;
               cnt <= '0;
               if (err_ill || err_mis) state <= DONE;
               else begin
                  mem_addr <= {addr[63:3], 3'b000};
                  state <= is_store && funct3 == F3_D ? WRITE : RD_WAIT;
               end
            end
            RD_WAIT: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'(MEM_LATENCY)) begin
                  rdata_q <= mem_rdata;
                  state <= st_q ? WRITE : DONE;
               end
            end
            WRITE: begin
               mem_wr <= 1'b1;
               mem_wdata <= lane_wdata;
               state <= DONE;
            end
            DONE: begin
               done <= 1'b1;
               misaligned <= mis_q;
               illegal <= ill_q;
               if (!st_q && !mis_q && !ill_q) load_data <= lane_load;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
